// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: prioritises cache, multi-cycle and hazard stalls
// against exceptions, drives per-stage stall/flush, and counts stalled cycles.
module pipeline_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             icache_stall_req,
  input  logic             dcache_stall_req,
  input  logic             muldiv_busy,
  input  logic             load_use_hazard,
  input  logic             exc_req,
  input  logic             eret_req,
  input  logic             cnt_clr,
  output logic             PC_Stall,
  output logic             IF_ID_Stall,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Stall,
  output logic             ID_EX_Flush,
  output logic             EX_MEM_Stall,
  output logic             EX_MEM_Flush,
  output logic             MEM_WB_Stall,
  output logic             MEM_WB_Flush,
  output logic             exc_redirect,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    MEM_WAIT  = 2'd1,
    MD_WAIT   = 2'd2,
    EXC_FLUSH = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_exc_pending;
  logic             w_exc_pending_nxt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_exc_eff;

  // An exception arriving under a data-cache miss is held until the miss resolves.
  assign w_exc_eff = (exc_req | eret_req | r_exc_pending) & ~dcache_stall_req;

  // NOTE: every signal written here gets a default first, so no path leaves a latch.
  always_comb begin
    w_state_nxt       = RUN;
    w_exc_pending_nxt = r_exc_pending;
    PC_Stall          = 1'b0;
    IF_ID_Stall       = 1'b0;
    IF_ID_Flush       = 1'b0;
    ID_EX_Stall       = 1'b0;
    ID_EX_Flush       = 1'b0;
    EX_MEM_Stall      = 1'b0;
    EX_MEM_Flush      = 1'b0;
    MEM_WB_Stall      = 1'b0;
    MEM_WB_Flush      = 1'b0;

    if (w_exc_eff) begin
      w_exc_pending_nxt = 1'b0;
    end else if ((exc_req | eret_req) & dcache_stall_req) begin
      w_exc_pending_nxt = 1'b1;
    end

    // Reset masks every control output even though the inputs may be active.
    if (rst_n) begin
      if (w_exc_eff) begin
        IF_ID_Flush  = 1'b1;
        ID_EX_Flush  = 1'b1;
        EX_MEM_Flush = 1'b1;
        MEM_WB_Flush = 1'b1;
        w_state_nxt  = EXC_FLUSH;
      end else if (dcache_stall_req) begin
        PC_Stall     = 1'b1;
        IF_ID_Stall  = 1'b1;
        ID_EX_Stall  = 1'b1;
        EX_MEM_Stall = 1'b1;
        MEM_WB_Flush = 1'b1;
        w_state_nxt  = MEM_WAIT;
      end else if (muldiv_busy) begin
        PC_Stall     = 1'b1;
        IF_ID_Stall  = 1'b1;
        ID_EX_Stall  = 1'b1;
        EX_MEM_Flush = 1'b1;
        w_state_nxt  = MD_WAIT;
      end else if (load_use_hazard) begin
        PC_Stall     = 1'b1;
        IF_ID_Stall  = 1'b1;
        ID_EX_Flush  = 1'b1;
      end else if (icache_stall_req) begin
        PC_Stall     = 1'b1;
        IF_ID_Flush  = 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignment so all flops sample together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= RUN;
      r_exc_pending <= 1'b0;
      r_stall_cnt   <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_exc_pending <= w_exc_pending_nxt;
      if (cnt_clr) begin
        r_stall_cnt <= '0;
      end else if (PC_Stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
    end
  end

  assign exc_redirect = (r_state == EXC_FLUSH);
  assign state_o      = r_state;
  assign stall_cnt    = r_stall_cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed-vector bench for pipeline_ctrl; a second instance with CNT_W=4
// exercises stall counter saturation.
module tb_pipeline_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic icache_stall_req, dcache_stall_req, muldiv_busy, load_use_hazard;
  logic exc_req, eret_req, cnt_clr;
  logic PC_Stall, IF_ID_Stall, IF_ID_Flush, ID_EX_Stall, ID_EX_Flush;
  logic EX_MEM_Stall, EX_MEM_Flush, MEM_WB_Stall, MEM_WB_Flush;
  logic exc_redirect;
  logic [1:0]  state_o;
  logic [15:0] stall_cnt;
  logic PC_Stall4, IF_ID_Stall4, IF_ID_Flush4, ID_EX_Stall4, ID_EX_Flush4;
  logic EX_MEM_Stall4, EX_MEM_Flush4, MEM_WB_Stall4, MEM_WB_Flush4;
  logic exc_redirect4;
  logic [1:0]  state_o4;
  logic [3:0]  stall_cnt4;

  int pass_cnt  = 0;
  int check_cnt = 0;

  // Output vector order: PC_S IFID_S IFID_F IDEX_S IDEX_F EXMEM_S EXMEM_F MEMWB_S MEMWB_F
  localparam logic [8:0] V_NONE = 9'b000000000;
  localparam logic [8:0] V_DC   = 9'b110101001;
  localparam logic [8:0] V_MD   = 9'b110100100;
  localparam logic [8:0] V_LU   = 9'b110010000;
  localparam logic [8:0] V_IC   = 9'b101000000;
  localparam logic [8:0] V_EX   = 9'b001010101;

  always #5 clk = ~clk;

  pipeline_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .icache_stall_req(icache_stall_req), .dcache_stall_req(dcache_stall_req),
    .muldiv_busy(muldiv_busy), .load_use_hazard(load_use_hazard),
    .exc_req(exc_req), .eret_req(eret_req), .cnt_clr(cnt_clr),
    .PC_Stall(PC_Stall), .IF_ID_Stall(IF_ID_Stall), .IF_ID_Flush(IF_ID_Flush),
    .ID_EX_Stall(ID_EX_Stall), .ID_EX_Flush(ID_EX_Flush),
    .EX_MEM_Stall(EX_MEM_Stall), .EX_MEM_Flush(EX_MEM_Flush),
    .MEM_WB_Stall(MEM_WB_Stall), .MEM_WB_Flush(MEM_WB_Flush),
    .exc_redirect(exc_redirect), .state_o(state_o), .stall_cnt(stall_cnt)
  );

  pipeline_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .icache_stall_req(icache_stall_req), .dcache_stall_req(dcache_stall_req),
    .muldiv_busy(muldiv_busy), .load_use_hazard(load_use_hazard),
    .exc_req(exc_req), .eret_req(eret_req), .cnt_clr(cnt_clr),
    .PC_Stall(PC_Stall4), .IF_ID_Stall(IF_ID_Stall4), .IF_ID_Flush(IF_ID_Flush4),
    .ID_EX_Stall(ID_EX_Stall4), .ID_EX_Flush(ID_EX_Flush4),
    .EX_MEM_Stall(EX_MEM_Stall4), .EX_MEM_Flush(EX_MEM_Flush4),
    .MEM_WB_Stall(MEM_WB_Stall4), .MEM_WB_Flush(MEM_WB_Flush4),
    .exc_redirect(exc_redirect4), .state_o(state_o4), .stall_cnt(stall_cnt4)
  );

  function automatic logic [8:0] outs();
    return {PC_Stall, IF_ID_Stall, IF_ID_Flush, ID_EX_Stall, ID_EX_Flush,
            EX_MEM_Stall, EX_MEM_Flush, MEM_WB_Stall, MEM_WB_Flush};
  endfunction

  // Registered values are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    icache_stall_req = 1'b0; dcache_stall_req = 1'b0; muldiv_busy = 1'b0;
    load_use_hazard  = 1'b0; exc_req = 1'b0; eret_req = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    step(); step();
    icache_stall_req = 1'b1; dcache_stall_req = 1'b1; muldiv_busy = 1'b1;
    load_use_hazard = 1'b1; exc_req = 1'b1; eret_req = 1'b1;
    #1;
    check_cnt++; if (outs() !== V_NONE) $display("FAIL reset_outs: got %b expected %b", outs(), V_NONE); else pass_cnt++;
    step();
    check_cnt++; if (state_o !== 2'd0) $display("FAIL reset_state: got %0d expected 0", state_o); else pass_cnt++;
    check_cnt++; if (stall_cnt !== 16'd0) $display("FAIL reset_cnt: got %0d expected 0", stall_cnt); else pass_cnt++;
    check_cnt++; if (exc_redirect !== 1'b0) $display("FAIL reset_redirect: got %b expected 0", exc_redirect); else pass_cnt++;
    clear_inputs();
    rst_n = 1'b1;
    step();
    check_cnt++; if (state_o !== 2'd0) $display("FAIL idle_state: got %0d expected 0", state_o); else pass_cnt++;
    check_cnt++; if (outs() !== V_NONE) $display("FAIL idle_outs: got %b expected %b", outs(), V_NONE); else pass_cnt++;
  endtask

  task automatic test_run_hazards();
    icache_stall_req = 1'b1; #1;
    check_cnt++; if (outs() !== V_IC) $display("FAIL icache_outs: got %b expected %b", outs(), V_IC); else pass_cnt++;
    step();
    check_cnt++; if (state_o !== 2'd0) $display("FAIL icache_state: got %0d expected 0", state_o); else pass_cnt++;
    load_use_hazard = 1'b1; #1;
    check_cnt++; if (outs() !== V_LU) $display("FAIL loaduse_over_icache: got %b expected %b", outs(), V_LU); else pass_cnt++;
    step();
    check_cnt++; if (state_o !== 2'd0) $display("FAIL loaduse_state: got %0d expected 0", state_o); else pass_cnt++;
    clear_inputs(); #1;
    check_cnt++; if (outs() !== V_NONE) $display("FAIL hazard_release: got %b expected %b", outs(), V_NONE); else pass_cnt++;
    step();
  endtask

  task automatic test_dcache();
    cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
    check_cnt++; if (stall_cnt !== 16'd0) $display("FAIL cnt_clr: got %0d expected 0", stall_cnt); else pass_cnt++;
    dcache_stall_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_cnt++; if (outs() !== V_DC) $display("FAIL dcache_outs[%0d]: got %b expected %b", i, outs(), V_DC); else pass_cnt++;
      step();
      check_cnt++; if (state_o !== 2'd1) $display("FAIL dcache_state[%0d]: got %0d expected 1", i, state_o); else pass_cnt++;
      check_cnt++; if (stall_cnt !== 16'(i + 1)) $display("FAIL dcache_cnt[%0d]: got %0d expected %0d", i, stall_cnt, i + 1); else pass_cnt++;
    end
    dcache_stall_req = 1'b0; #1;
    check_cnt++; if (outs() !== V_NONE) $display("FAIL dcache_release: got %b expected %b", outs(), V_NONE); else pass_cnt++;
    step();
    check_cnt++; if (state_o !== 2'd0) $display("FAIL dcache_to_run: got %0d expected 0", state_o); else pass_cnt++;
    check_cnt++; if (stall_cnt !== 16'd3) $display("FAIL dcache_cnt_final: got %0d expected 3", stall_cnt); else pass_cnt++;
  endtask

  task automatic test_exc_during_dcache();
    dcache_stall_req = 1'b1; exc_req = 1'b1; #1;
    check_cnt++; if (outs() !== V_DC) $display("FAIL exc_masked: got %b expected %b", outs(), V_DC); else pass_cnt++;
    step();
    exc_req = 1'b0; #1;
    check_cnt++; if (outs() !== V_DC) $display("FAIL exc_held: got %b expected %b", outs(), V_DC); else pass_cnt++;
    step();
    dcache_stall_req = 1'b0; #1;
    check_cnt++; if (outs() !== V_EX) $display("FAIL exc_pending_flush: got %b expected %b", outs(), V_EX); else pass_cnt++;
    check_cnt++; if (exc_redirect !== 1'b0) $display("FAIL redirect_early: got %b expected 0", exc_redirect); else pass_cnt++;
    step();
    check_cnt++; if (state_o !== 2'd3) $display("FAIL exc_state: got %0d expected 3", state_o); else pass_cnt++;
    check_cnt++; if (exc_redirect !== 1'b1) $display("FAIL exc_redirect: got %b expected 1", exc_redirect); else pass_cnt++;
    check_cnt++; if (outs() !== V_NONE) $display("FAIL pending_cleared: got %b expected %b", outs(), V_NONE); else pass_cnt++;
    step();
    check_cnt++; if (state_o !== 2'd0) $display("FAIL exc_one_cycle: got %0d expected 0", state_o); else pass_cnt++;
    check_cnt++; if (exc_redirect !== 1'b0) $display("FAIL redirect_drop: got %b expected 0", exc_redirect); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    eret_req = 1'b1; #1;
    check_cnt++; if (outs() !== V_EX) $display("FAIL eret_outs: got %b expected %b", outs(), V_EX); else pass_cnt++;
    step();
    eret_req = 1'b0; exc_req = 1'b1; #1;
    check_cnt++; if (outs() !== V_EX) $display("FAIL b2b_outs: got %b expected %b", outs(), V_EX); else pass_cnt++;
    step();
    check_cnt++; if (state_o !== 2'd3 || exc_redirect !== 1'b1) $display("FAIL b2b_second_pulse: got state %0d redirect %b expected 3/1", state_o, exc_redirect); else pass_cnt++;
    exc_req = 1'b0;
    step();
    check_cnt++; if (state_o !== 2'd0 || exc_redirect !== 1'b0) $display("FAIL b2b_end: got state %0d redirect %b expected 0/0", state_o, exc_redirect); else pass_cnt++;
  endtask

  task automatic test_muldiv();
    muldiv_busy = 1'b1; load_use_hazard = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      check_cnt++; if (outs() !== V_MD) $display("FAIL md_outs[%0d]: got %b expected %b", i, outs(), V_MD); else pass_cnt++;
      step();
      check_cnt++; if (state_o !== 2'd2) $display("FAIL md_state[%0d]: got %0d expected 2", i, state_o); else pass_cnt++;
    end
    muldiv_busy = 1'b0; load_use_hazard = 1'b0;
    step();
    check_cnt++; if (state_o !== 2'd0) $display("FAIL md_to_run: got %0d expected 0", state_o); else pass_cnt++;
    dcache_stall_req = 1'b1; muldiv_busy = 1'b1; #1;
    check_cnt++; if (outs() !== V_DC) $display("FAIL dc_over_md: got %b expected %b", outs(), V_DC); else pass_cnt++;
    step();
    dcache_stall_req = 1'b0; #1;
    check_cnt++; if (outs() !== V_MD) $display("FAIL memwait_md_outs: got %b expected %b", outs(), V_MD); else pass_cnt++;
    step();
    check_cnt++; if (state_o !== 2'd2) $display("FAIL memwait_to_md: got %0d expected 2", state_o); else pass_cnt++;
    muldiv_busy = 1'b0;
    step();
  endtask

  task automatic test_saturation();
    cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
    icache_stall_req = 1'b1;
    for (int i = 0; i < 20; i++) step();
    check_cnt++; if (stall_cnt4 !== 4'd15) $display("FAIL sat4: got %0d expected 15", stall_cnt4); else pass_cnt++;
    check_cnt++; if (stall_cnt !== 16'd20) $display("FAIL cnt16: got %0d expected 20", stall_cnt); else pass_cnt++;
    cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
    check_cnt++; if (stall_cnt4 !== 4'd0) $display("FAIL clr_wins4: got %0d expected 0", stall_cnt4); else pass_cnt++;
    check_cnt++; if (stall_cnt !== 16'd0) $display("FAIL clr_wins16: got %0d expected 0", stall_cnt); else pass_cnt++;
    icache_stall_req = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    muldiv_busy = 1'b1;
    step(); step();
    check_cnt++; if (state_o !== 2'd2) $display("FAIL pre_reset_md: got %0d expected 2", state_o); else pass_cnt++;
    rst_n = 1'b0; #1;
    check_cnt++; if (state_o !== 2'd0 || outs() !== V_NONE) $display("FAIL mid_reset: got state %0d outs %b expected 0/%b", state_o, outs(), V_NONE); else pass_cnt++;
    check_cnt++; if (stall_cnt !== 16'd0) $display("FAIL mid_reset_cnt: got %0d expected 0", stall_cnt); else pass_cnt++;
    step();
    rst_n = 1'b1; #1;
    check_cnt++; if (outs() !== V_MD) $display("FAIL post_reset_md_outs: got %b expected %b", outs(), V_MD); else pass_cnt++;
    step();
    check_cnt++; if (state_o !== 2'd2) $display("FAIL post_reset_md_state: got %0d expected 2", state_o); else pass_cnt++;
    muldiv_busy = 1'b0;
    dcache_stall_req = 1'b1; exc_req = 1'b1;
    step();
    exc_req = 1'b0;
    rst_n = 1'b0; #1;
    dcache_stall_req = 1'b0;
    step();
    rst_n = 1'b1; #1;
    check_cnt++; if (outs() !== V_NONE) $display("FAIL pending_dropped: got %b expected %b", outs(), V_NONE); else pass_cnt++;
    step();
    check_cnt++; if (state_o !== 2'd0 || exc_redirect !== 1'b0) $display("FAIL post_reset_run: got state %0d redirect %b expected 0/0", state_o, exc_redirect); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_run_hazards();
    test_dcache();
    test_exc_during_dcache();
    test_back_to_back();
    test_muldiv();
    test_saturation();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 The module SHALL have parameter CNT_W, default 16, setting the stall-cycle counter width.
REQ-002 The module SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-004 The module SHALL have request inputs, 1 bit each: icache_stall_req (IF miss), dcache_stall_req (MEM miss), muldiv_busy (EX multi-cycle op), load_use_hazard (ID), exc_req (exception from MEM), eret_req (ERET in MEM).
REQ-005 The module SHALL have input cnt_clr, 1, synchronous clear of stall_cnt.
REQ-006 The module SHALL have outputs, 1 bit each: PC_Stall, IF_ID_Stall, IF_ID_Flush, ID_EX_Stall, ID_EX_Flush, EX_MEM_Stall, EX_MEM_Flush, MEM_WB_Stall, MEM_WB_Flush, for the per-stage pipeline registers.
REQ-007 The module SHALL have output exc_redirect, 1, one-cycle pulse steering PC to the exception/EPC target.
REQ-008 The module SHALL have outputs state_o, 2, current FSM state, and stall_cnt, CNT_W, saturating stall-cycle count.

Function
REQ-009 The FSM SHALL have states RUN=0, MEM_WAIT=1, MD_WAIT=2, EXC_FLUSH=3.
REQ-010 The effective exception request SHALL be exc_eff = (exc_req | eret_req | exc_pending) & ~dcache_stall_req.
REQ-011 exc_pending SHALL set when (exc_req|eret_req) is high while dcache_stall_req is high, and SHALL clear on the cycle exc_eff is high.
REQ-012 Priority, highest first: exc_eff, dcache_stall_req, muldiv_busy, load_use_hazard, icache_stall_req; only the highest active source drives stall/flush outputs.
REQ-013 exc_eff SHALL assert IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush, MEM_WB_Flush with all stalls 0, and next state EXC_FLUSH.
REQ-014 dcache_stall_req SHALL assert PC_Stall, IF_ID_Stall, ID_EX_Stall, EX_MEM_Stall and MEM_WB_Flush; next state MEM_WAIT.
REQ-015 muldiv_busy SHALL assert PC_Stall, IF_ID_Stall, ID_EX_Stall and EX_MEM_Flush; next state MD_WAIT.
REQ-016 load_use_hazard SHALL assert PC_Stall, IF_ID_Stall and ID_EX_Flush; state stays RUN.
REQ-017 icache_stall_req alone SHALL assert PC_Stall and IF_ID_Flush; state stays RUN.
REQ-018 Stall/flush outputs SHALL be combinational from current inputs and exc_pending; no flush and stall SHALL be high on the same stage register simultaneously.
REQ-019 MEM_WAIT and MD_WAIT SHALL return to RUN the first cycle their request is low, unless a higher-priority source selects another state.
REQ-020 EXC_FLUSH SHALL last exactly one cycle, then RUN (or the state selected by requests active then); exc_redirect SHALL be high exactly in EXC_FLUSH.
REQ-021 A new exc_req during EXC_FLUSH SHALL be serviced normally (re-enter EXC_FLUSH, second redirect pulse).
REQ-022 stall_cnt SHALL increment by 1 each cycle PC_Stall is high, saturate at 2^CNT_W-1, and clear to 0 on cnt_clr (cnt_clr wins over increment).
REQ-023 With no request active all stall/flush outputs SHALL be 0.

Reset
REQ-024 While rst_n is low, state SHALL be RUN, exc_pending 0, stall_cnt 0, exc_redirect 0, and all stall/flush outputs forced 0 regardless of inputs.
REQ-025 Reset asserted mid-operation (any state) SHALL abandon it immediately; first cycle after release behaves as RUN with exc_pending 0.

Verification
REQ-026 dcache_stall_req high 3 cycles -> PC/IF_ID/ID_EX/EX_MEM_Stall=1, MEM_WB_Flush=1 for 3 cycles, state_o=1, stall_cnt=3, then RUN.
REQ-027 exc_req pulsed during dcache stall -> no flush while stall high; first cycle stall low: all four flushes=1, next cycle exc_redirect=1, state_o=3, exc_pending cleared.
REQ-028 muldiv_busy and load_use_hazard together 2 cycles -> EX_MEM_Flush=1, ID_EX_Flush=0, state_o=2, then RUN.
REQ-029 CNT_W=4, PC_Stall held 20 cycles -> stall_cnt=15 held; cnt_clr with PC_Stall high -> stall_cnt=0.
REQ-030 rst_n low during MD_WAIT with muldiv_busy=1 -> all outputs 0, state_o=0; release with muldiv_busy=1 -> MD_WAIT entered normally.
